// File: rtl/mio_bus_arbiter_if.sv
// Bus bundle shared by the CPU requester, the debug/DMA requester,
// the single-port data memory and the arbiter that sits between them.
interface mio_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // requester 0 (CPU)
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          rdy0;
    logic [DW-1:0] rdata0;
    // requester 1 (debug/DMA)
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          rdy1;
    logic [DW-1:0] rdata1;
    // memory side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    // status
    logic [1:0]    grant;
    logic          busy;

    // arbiter view
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output rdy0, rdata0, rdy1, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output grant, busy
    );

    // requester/memory view
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  rdy0, rdata0, rdy1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  grant, busy
    );
endinterface

// File: rtl/mio_bus_arbiter.sv
// Two-requester round-robin arbiter for the SCPU data memory port.
// Requester 0 is the CPU (its rdy drives MIO_ready), requester 1 the
// debug/DMA loader. An access holds the memory for MEM_LAT+1 cycles,
// then pulses the owner's rdy for one cycle in RESP. RESP never samples
// requests, so an owner that drops req on rdy is not granted again.
module mio_bus_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic             clk,
    input  logic             rst,
    mio_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_C = 4'(MEM_LAT);

    state_t        state_r, state_s;
    logic          last_grant_r, last_grant_s;  // 1: requester 1 owned last
    logic [3:0]    cnt_r, cnt_s;
    logic          mem_en_r, mem_en_s;
    logic          mem_we_r, mem_we_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_s;
    logic [1:0]    grant_r, grant_s;
    logic          busy_r, busy_s;
    logic          rdy0_r, rdy0_s;
    logic          rdy1_r, rdy1_s;
    logic [DW-1:0] rdata0_r, rdata0_s;
    logic [DW-1:0] rdata1_r, rdata1_s;
    logic          pick1_s;

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        cnt_s        = cnt_r;
        mem_en_s     = mem_en_r;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        grant_s      = grant_r;
        busy_s       = busy_r;
        rdy0_s       = 1'b0;
        rdy1_s       = 1'b0;
        rdata0_s     = rdata0_r;
        rdata1_s     = rdata1_r;
        pick1_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // on a tie the requester that did not own the memory last wins
                if (bus.req0 && bus.req1) begin
                    pick1_s = ~last_grant_r;
                end else if (bus.req1) begin
                    pick1_s = 1'b1;
                end else begin
                    pick1_s = 1'b0;
                end

                if (bus.req0 || bus.req1) begin
                    state_s      = ST_ACCESS;
                    last_grant_s = pick1_s;
                    cnt_s        = 4'd0;
                    mem_en_s     = 1'b1;
                    busy_s       = 1'b1;
                    grant_s      = pick1_s ? 2'b10 : 2'b01;
                    mem_we_s     = pick1_s ? bus.we1    : bus.we0;
                    mem_addr_s   = pick1_s ? bus.addr1  : bus.addr0;
                    mem_wdata_s  = pick1_s ? bus.wdata1 : bus.wdata0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                cnt_s = cnt_r + 4'd1;
                if (cnt_r == LAT_C) begin
                    state_s  = ST_RESP;
                    mem_en_s = 1'b0;
                    mem_we_s = 1'b0;
                    if (grant_r[1]) begin
                        rdy1_s   = 1'b1;
                        rdata1_s = bus.mem_rdata;
                    end else begin
                        rdy0_s   = 1'b1;
                        rdata0_s = bus.mem_rdata;
                    end
                end else begin
                    state_s = ST_ACCESS;
                end
            end

            ST_RESP: begin
                state_s = ST_IDLE;
                grant_s = 2'b00;
                busy_s  = 1'b0;
            end

            default: begin
                state_s  = ST_IDLE;
                grant_s  = 2'b00;
                busy_s   = 1'b0;
                mem_en_s = 1'b0;
                mem_we_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            cnt_r        <= 4'd0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {AW{1'b0}};
            mem_wdata_r  <= {DW{1'b0}};
            grant_r      <= 2'b00;
            busy_r       <= 1'b0;
            rdy0_r       <= 1'b0;
            rdy1_r       <= 1'b0;
            rdata0_r     <= {DW{1'b0}};
            rdata1_r     <= {DW{1'b0}};
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            cnt_r        <= cnt_s;
            mem_en_r     <= mem_en_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            grant_r      <= grant_s;
            busy_r       <= busy_s;
            rdy0_r       <= rdy0_s;
            rdy1_r       <= rdy1_s;
            rdata0_r     <= rdata0_s;
            rdata1_r     <= rdata1_s;
        end
    end

    assign bus.rdy0      = rdy0_r;
    assign bus.rdata0    = rdata0_r;
    assign bus.rdy1      = rdy1_r;
    assign bus.rdata1    = rdata1_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.grant     = grant_r;
    assign bus.busy      = busy_r;

endmodule
